// File: rtl/trng_postproc_if.sv
// Raw-bit input and packed-byte output signals of the TRNG post-processor.
// Handshake: a byte moves on a rising edge where byte_valid & byte_ready; byte_out holds while byte_valid & ~byte_ready.
interface trng_postproc_if;
  logic       raw_bit;
  logic       raw_valid;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ready;
  logic       health_fail;

  modport master (
    output raw_bit,
    output raw_valid,
    output byte_ready,
    input  byte_out,
    input  byte_valid,
    input  health_fail
  );

  modport slave (
    input  raw_bit,
    input  raw_valid,
    input  byte_ready,
    output byte_out,
    output byte_valid,
    output health_fail
  );
endinterface

// File: rtl/trng_postproc.sv
// TRNG post-processing: repetition-count health test, von Neumann debiasing,
// byte packing with a one-deep hold buffer, and a valid/ready byte output.
module trng_postproc #(
  parameter int unsigned REP_LIMIT = 16
) (
  input logic            clk,
  input logic            rst,
  input logic            en,
  trng_postproc_if.slave bus
);

  localparam logic [7:0] LIMIT = 8'(REP_LIMIT);

  logic [7:0] rep_cnt;
  logic       last_bit;
  logic       phase;
  logic       first_bit;
  logic [7:0] pk_data;
  logic [2:0] pk_cnt;
  logic       pk_full;
  logic [7:0] byte_q;
  logic       valid_q;
  logic       fail_q;

  logic       accept;
  logic [7:0] rep_next;
  logic       fail_now;
  logic       emit;
  logic       out_free;
  logic [7:0] pk_next;

  assign accept   = en & bus.raw_valid & ~fail_q;
  assign fail_now = accept & (rep_next == LIMIT);
  // Second bit of a pair that differs from the first: the first bit is the output (10 -> 1, 01 -> 0).
  assign emit     = accept & ~fail_now & phase & (first_bit != bus.raw_bit);
  assign out_free = ~valid_q | bus.byte_ready;
  assign pk_next  = {pk_data[6:0], first_bit};

  always_comb begin
    rep_next = 8'd1;
    if ((rep_cnt != 8'd0) && (bus.raw_bit == last_bit)) begin
      rep_next = (rep_cnt == LIMIT) ? rep_cnt : rep_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cnt   <= 8'd0;
      last_bit  <= 1'b0;
      phase     <= 1'b0;
      first_bit <= 1'b0;
      pk_data   <= 8'd0;
      pk_cnt    <= 3'd0;
      pk_full   <= 1'b0;
      byte_q    <= 8'd0;
      valid_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else if (fail_now) begin
      // Failure flushes everything downstream; the failing bit never reaches the corrector.
      fail_q  <= 1'b1;
      rep_cnt <= rep_next;
      phase   <= 1'b0;
      pk_data <= 8'd0;
      pk_cnt  <= 3'd0;
      pk_full <= 1'b0;
      byte_q  <= 8'd0;
      valid_q <= 1'b0;
    end else begin
      if (accept) begin
        rep_cnt  <= rep_next;
        last_bit <= bus.raw_bit;
        phase    <= ~phase;
        if (!phase) first_bit <= bus.raw_bit;
      end else if (!en) begin
        phase <= 1'b0;
      end

      if (valid_q && bus.byte_ready) valid_q <= 1'b0;

      // While a byte is held, newly corrected bits are dropped.
      if (pk_full) begin
        if (out_free) begin
          byte_q  <= pk_data;
          valid_q <= 1'b1;
          pk_full <= 1'b0;
          pk_cnt  <= 3'd0;
        end
      end else if (emit) begin
        if (pk_cnt == 3'd7) begin
          pk_cnt <= 3'd0;
          if (out_free) begin
            byte_q  <= pk_next;
            valid_q <= 1'b1;
          end else begin
            pk_data <= pk_next;
            pk_full <= 1'b1;
          end
        end else begin
          pk_data <= pk_next;
          pk_cnt  <= pk_cnt + 3'd1;
        end
      end
    end
  end

  assign bus.byte_out    = byte_q;
  assign bus.byte_valid  = valid_q;
  assign bus.health_fail = fail_q;

endmodule

// File: tb/tb_trng_postproc.sv
// Self-checking bench for trng_postproc: directed scenarios plus a byte scoreboard on the output handshake.
module tb_trng_postproc;

  logic clk;
  logic rst;
  logic en;
  trng_postproc_if bus ();

  int tests_run;
  int tests_failed;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;

  trng_postproc #(.REP_LIMIT(16)) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .bus (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.raw_valid = 1'b0;
    cycle();
    rst = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (bus.byte_valid === 1'b1 && bus.byte_ready === 1'b1) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_byte: got %h, required no byte", bus.byte_out);
      end else begin
        exp_b = exp_q.pop_front();
        if (bus.byte_out !== exp_b) begin
          tests_failed++;
          $display("FAIL sb_byte: got %h, required %h", bus.byte_out, exp_b);
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic send_bit(input logic b);
    bus.raw_bit   = b;
    bus.raw_valid = 1'b1;
    cycle();
    bus.raw_valid = 1'b0;
  endtask

  // One von Neumann pair per data bit: 1 -> "10", 0 -> "01"; MSB first.
  task automatic send_pairs(input logic [7:0] v, input int first, input int count);
    for (int i = first; i < first + count; i++) begin
      send_bit(v[7-i]);
      send_bit(~v[7-i]);
    end
  endtask

  // Full byte with latency check: valid must be low before the 16th raw bit and high right after it.
  task automatic send_byte_checked(input logic [7:0] v);
    send_pairs(v, 0, 7);
    send_bit(v[0]);
    tests_run++;
    if (bus.byte_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL early_valid: got %b, required 0 (byte %h)", bus.byte_valid, v);
    end
    send_bit(~v[0]);
    tests_run++;
    if (bus.byte_valid !== 1'b1 || bus.byte_out !== v) begin
      tests_failed++;
      $display("FAIL byte_latency: got valid=%b data=%h, required valid=1 data=%h",
               bus.byte_valid, bus.byte_out, v);
    end
  endtask

  task automatic check_drained(input string name);
    tests_run++;
    if (exp_q.size() != 0 || bus.byte_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_drained: got pending=%0d valid=%b, required 0 and 0",
               name, exp_q.size(), bus.byte_valid);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      en             = 1'($urandom_range(0, 1));
      bus.raw_bit    = 1'($urandom_range(0, 1));
      bus.raw_valid  = 1'($urandom_range(0, 1));
      bus.byte_ready = 1'($urandom_range(0, 1));
      cycle();
      tests_run++;
      if (bus.byte_out !== 8'h00 || bus.byte_valid !== 1'b0 || bus.health_fail !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_outputs: got data=%h valid=%b fail=%b, required 00 0 0",
                 bus.byte_out, bus.byte_valid, bus.health_fail);
      end
    end
    rst = 1'b0;
    bus.raw_valid = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      tests_run++;
      if (bus.byte_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_idle_valid: got %b, required 0", bus.byte_valid);
      end
    end
  endtask

  task automatic test_basic();
    do_reset();
    en = 1'b1;
    bus.byte_ready = 1'b1;
    exp_q.push_back(8'hB2);
    send_byte_checked(8'hB2);
    repeat (3) cycle();
    check_drained("basic");
  endtask

  task automatic test_discard();
    logic [7:0] v;
    do_reset();
    en = 1'b1;
    bus.byte_ready = 1'b1;
    v = 8'hB2;
    exp_q.push_back(v);
    for (int i = 0; i < 7; i++) begin
      send_pairs(v, i, 1);
      send_bit(i[0]);
      send_bit(i[0]);
    end
    send_bit(v[0]);
    tests_run++;
    if (bus.byte_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL discard_early: got %b, required 0", bus.byte_valid);
    end
    send_bit(~v[0]);
    tests_run++;
    if (bus.byte_valid !== 1'b1 || bus.byte_out !== v) begin
      tests_failed++;
      $display("FAIL discard_byte: got valid=%b data=%h, required 1 %h",
               bus.byte_valid, bus.byte_out, v);
    end
    repeat (6) cycle();
    check_drained("discard");
  endtask

  task automatic test_back_to_back();
    do_reset();
    en = 1'b1;
    bus.byte_ready = 1'b1;
    exp_q.push_back(8'hB2);
    exp_q.push_back(8'h4D);
    exp_q.push_back(8'h96);
    send_byte_checked(8'hB2);
    send_byte_checked(8'h4D);
    send_byte_checked(8'h96);
    repeat (3) cycle();
    check_drained("b2b");
  endtask

  task automatic test_backpressure();
    do_reset();
    en = 1'b1;
    bus.byte_ready = 1'b0;
    exp_q.push_back(8'hB2);
    exp_q.push_back(8'h4D);
    send_byte_checked(8'hB2);
    send_pairs(8'h4D, 0, 8);
    tests_run++;
    if (bus.byte_valid !== 1'b1 || bus.byte_out !== 8'hB2) begin
      tests_failed++;
      $display("FAIL bp_hold: got valid=%b data=%h, required 1 b2", bus.byte_valid, bus.byte_out);
    end
    send_pairs(8'hFF, 0, 8);
    tests_run++;
    if (bus.byte_out !== 8'hB2) begin
      tests_failed++;
      $display("FAIL bp_hold_third: got %h, required b2", bus.byte_out);
    end
    cycle();
    bus.byte_ready = 1'b1;
    cycle();
    tests_run++;
    if (bus.byte_valid !== 1'b1 || bus.byte_out !== 8'h4D) begin
      tests_failed++;
      $display("FAIL bp_second: got valid=%b data=%h, required 1 4d", bus.byte_valid, bus.byte_out);
    end
    repeat (20) cycle();
    check_drained("bp");
  endtask

  task automatic test_health();
    do_reset();
    en = 1'b1;
    bus.byte_ready = 1'b1;
    for (int i = 0; i < 15; i++) send_bit(1'b1);
    send_bit(1'b0);
    tests_run++;
    if (bus.health_fail !== 1'b0) begin
      tests_failed++;
      $display("FAIL health_15_ones: got %b, required 0", bus.health_fail);
    end
    for (int i = 0; i < 14; i++) send_bit(1'b0);
    tests_run++;
    if (bus.health_fail !== 1'b0) begin
      tests_failed++;
      $display("FAIL health_15_zeros: got %b, required 0", bus.health_fail);
    end
    send_bit(1'b0);
    tests_run++;
    if (bus.health_fail !== 1'b1 || bus.byte_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL health_trip: got fail=%b valid=%b, required 1 0", bus.health_fail, bus.byte_valid);
    end
    for (int i = 0; i < 24; i++) begin
      bus.byte_ready = 1'($urandom_range(0, 1));
      send_bit(1'($urandom_range(0, 1)));
      tests_run++;
      if (bus.health_fail !== 1'b1 || bus.byte_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL health_sticky: got fail=%b valid=%b, required 1 0", bus.health_fail, bus.byte_valid);
      end
    end
    bus.byte_ready = 1'b1;
    do_reset();
    tests_run++;
    if (bus.health_fail !== 1'b0) begin
      tests_failed++;
      $display("FAIL health_clear: got %b, required 0", bus.health_fail);
    end
  endtask

  task automatic test_midop();
    // Enable gap: five held bits survive, half pair is discarded.
    do_reset();
    en = 1'b1;
    bus.byte_ready = 1'b1;
    exp_q.push_back(8'hB2);
    send_pairs(8'hB2, 0, 5);
    send_bit(1'b1);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.raw_bit   = 1'($urandom_range(0, 1));
      bus.raw_valid = 1'b1;
      cycle();
    end
    bus.raw_valid = 1'b0;
    en = 1'b1;
    send_pairs(8'hB2, 5, 2);
    send_bit(1'b0);
    tests_run++;
    if (bus.byte_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL en_gap_early: got %b, required 0", bus.byte_valid);
    end
    send_bit(1'b1);
    tests_run++;
    if (bus.byte_valid !== 1'b1 || bus.byte_out !== 8'hB2) begin
      tests_failed++;
      $display("FAIL en_gap_byte: got valid=%b data=%h, required 1 b2", bus.byte_valid, bus.byte_out);
    end
    repeat (3) cycle();
    check_drained("en_gap");

    // Reset pulse: next byte built only from post-reset bits.
    send_pairs(8'h48, 0, 5);
    send_bit(1'b1);
    rst = 1'b1;
    bus.raw_bit   = 1'($urandom_range(0, 1));
    bus.raw_valid = 1'b1;
    cycle();
    rst = 1'b0;
    bus.raw_valid = 1'b0;
    exp_q.push_back(8'h4D);
    send_byte_checked(8'h4D);
    repeat (3) cycle();
    check_drained("rst_mid");
  endtask

  // ---------------- main ----------------
  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    rst            = 1'b1;
    en             = 1'b0;
    bus.raw_bit    = 1'b0;
    bus.raw_valid  = 1'b0;
    bus.byte_ready = 1'b0;
    test_reset();
    test_basic();
    test_discard();
    test_back_to_back();
    test_backpressure();
    test_health();
    test_midop();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/trng_postproc.md
# trng_postproc

Post-processing stage directly downstream of the TRNG entropy source inside `tt_um_roy1707018_roy1707018`. It consumes the sampled raw bit stream, runs a continuous repetition-count health test on it, and removes bias with a von Neumann corrector. It packs the corrected bits into bytes and presents them on a valid/ready output toward the top-level output pins.

## Interface
- `REP_LIMIT`, 16: run length of identical raw bits that declares health failure (2..255).
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset; one clock; reset is synchronous and active-high.
- `en`  in  1  sampling enable (driven from top-level `ena`).
- `raw_bit`  in  1  raw entropy bit, already synchronized upstream.
- `raw_valid`  in  1  qualifies `raw_bit`; one bit per cycle when high.
- `byte_out`  out  8  packed random byte.
- `byte_valid`  out  1  `byte_out` holds a valid byte.
- `byte_ready`  in  1  consumer accepts `byte_out` this cycle.
- `health_fail`  out  1  sticky repetition-test failure flag.

## Operation
- Raw bit is accepted on an edge where `en & raw_valid & ~health_fail`.
- Repetition test on every accepted raw bit:
  - `rep_cnt` resets to 0. The first accepted bit sets it to 1. A bit equal to the previous one increments it, saturating at `REP_LIMIT`. A differing bit sets it to 1.
  - `health_fail` sets on the edge where `rep_cnt` becomes `REP_LIMIT`. It is cleared only by `rst`.
- Von Neumann corrector:
  - A phase flag alternates on each accepted raw bit. The first bit of a pair is stored.
  - On the second bit: pair 10 emits 1, pair 01 emits 0, pairs 00 and 11 emit nothing.
- Packer:
  - Emitted bits shift in at bit0 with a left shift, so the first bit ends up at bit7.
  - A 3-bit count tracks the bits held.
  - On the 8th bit, the byte moves to the output register on the same edge if that register is free (`~byte_valid | byte_ready`). Otherwise the complete byte is held in the packer (`pk_full`).
  - While `pk_full`, emitted bits are dropped; raw bits are still health-tested.
  - A held byte moves to the output register on the first edge where it is free. The packer then restarts at count 0.
- Output handshake:
  - `byte_out` is stable while `byte_valid & ~byte_ready`.
  - A transfer occurs on an edge with `byte_valid & byte_ready`.
  - `byte_valid` stays high if a new byte loads on the same edge.
- `en` low:
  - Raw input is ignored.
  - The corrector phase is cleared, discarding any half pair.
  - Packer contents, `rep_cnt` and the output register are retained.
  - The output handshake keeps operating.
- On the edge that sets `health_fail`:
  - The packer, output register and `byte_valid` clear.
  - That raw bit is not used by the corrector.
  - `byte_valid` stays 0 until `rst`.

## Timing
- Reset values: `byte_out`=8'h00, `byte_valid`=0, `health_fail`=0. The internal phase, packer count, `pk_full` and `rep_cnt` are all 0.
- Byte latency: `byte_valid` is high after the edge that accepts the raw bit completing the 8th useful pair, with the output register free. There are no extra pipeline cycles.
- `health_fail` is high after the edge accepting the `REP_LIMIT`-th identical bit.
- Minimum raw bits per byte: 16. Maximum throughput is one byte per 16 cycles.
- Simultaneous cases on one edge:
  - Output transfer plus new byte load: the new byte wins, and `byte_valid` remains 1.
  - Transfer plus a `pk_full` move: the held byte loads.
  - `rst` with any event: reset wins.
- Reset mid-operation: partial bytes, the half pair and `rep_cnt` are discarded. The byte under construction after reset starts from count 0.

## Test plan
- Reset: hold `rst` 2 cycles with random inputs -> all outputs 0. After release, `byte_valid` stays 0 with `raw_valid`=0.
- Basic byte: with `en`=1 and `byte_ready`=1, feed pairs 10,01,10,10,01,01,10,01 back-to-back -> `byte_out`=8'hB2, and `byte_valid` is high exactly one cycle after the 16th raw bit.
- Discard: interleave pairs 00 and 11 between the pairs of the basic byte -> same 8'hB2, delayed by 2 cycles per discarded pair. No extra bytes.
- Backpressure:
  - With `byte_ready`=0, feed 8'hB2 then 8'h4D -> `byte_out` holds 8'hB2. A third byte's bits are dropped.
  - Raise `byte_ready` -> 8'hB2 transfers, then 8'h4D appears the next cycle. Nothing from the third byte appears.
- Health: with `REP_LIMIT`=16, send 15 ones then 0 -> `health_fail` stays 0. Then send 16 zeros -> `health_fail`=1 after the 16th zero, `byte_valid`=0 and stays 0 under further input until `rst`.
- Mid-op reset and enable: after 5 corrected bits plus a half pair, drop `en` 3 cycles and resume -> the half pair is discarded and the byte is completed with the 5 held bits. Repeat with `rst` pulsed instead -> the next byte is built entirely from post-reset bits.
